// File: rtl/xdma_id_alloc_pkg.sv
// Shared types and helpers for the XDMA transaction-ID allocator.
// Latency: n/a (types only). Backpressure: n/a.
package xdma_id_alloc_pkg;

  localparam int unsigned MaxN = 64;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } alloc_state_e;

  // Decode idx to a one-hot mask; indices at or beyond n decode to zero.
  function automatic logic [MaxN-1:0] onehot(input logic [5:0] idx, input int unsigned n);
    logic [MaxN-1:0] m;
    m = '0;
    if (32'(idx) < n) m[idx] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/find_first_one_idx.sv
// Lowest-set-bit priority encoder: valid_o=|in_i, idx_o=index of lowest set bit (0 if none).
// Latency: combinational. Backpressure: none.
module find_first_one_idx #(
  parameter int unsigned N = 8,
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    in_i,
  output logic            valid_o,
  output logic [IdxW-1:0] idx_o
);

  always_comb begin
    valid_o = |in_i;
    idx_o   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (in_i[i]) idx_o = IdxW'(i);
    end
  end

endmodule

// File: rtl/xdma_id_allocator.sv
// Outstanding-ID tracker: offers lowest free ID on valid/ready, takes IDs back on a release port.
// Latency: registered offer, 1 ID/cycle back-to-back; release-to-offer from full is 2 cycles (1 with XDMA_ID_ALLOC_BYPASS_EN).
// Backpressure: a pending offer holds stable while ready is low; illegal releases are dropped and flagged on err_o.
module xdma_id_allocator
  import xdma_id_alloc_pkg::*;
#(
  parameter int unsigned N = 8,
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1,
  localparam int unsigned CntW = $clog2(N + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  output logic            alloc_valid_o,
  input  logic            alloc_ready_i,
  output logic [IdxW-1:0] alloc_idx_o,
  input  logic            free_valid_i,
  input  logic [IdxW-1:0] free_idx_i,
  output logic [N-1:0]    busy_mask_o,
  output logic [CntW-1:0] count_o,
  output logic            full_o,
  output logic            empty_o,
  output logic            err_o
);

  localparam logic [N-1:0] ValidMask = '1;

  alloc_state_e    state_q, state_d;
  logic [IdxW-1:0] offer_idx_q, offer_idx_d;
  logic [N-1:0]    busy_q, busy_d;
  logic [CntW-1:0] count_q, count_d;
  logic            err_q, err_d;

  logic            accept;
  logic [N-1:0]    accept_onehot;
  logic [N-1:0]    free_onehot;
  logic            free_hit;
  logic [N-1:0]    free_clr;
  logic [N-1:0]    next_free;
  logic            ffo_valid;
  logic [IdxW-1:0] ffo_idx;

  assign alloc_valid_o = (state_q == OFFER);
  assign alloc_idx_o   = offer_idx_q;
  assign busy_mask_o   = busy_q;
  assign count_o       = count_q;
  assign full_o        = (count_q == CntW'(N));
  assign empty_o       = (count_q == '0);
  assign err_o         = err_q;

  assign accept        = alloc_valid_o & alloc_ready_i;
  assign accept_onehot = accept ? N'(onehot(6'(offer_idx_q), N)) : '0;

  // Out-of-range and not-busy releases (including the ID on offer) never hit.
  assign free_onehot   = N'(onehot(6'(free_idx_i), N));
  assign free_hit      = free_valid_i & (|(free_onehot & busy_q));
  assign free_clr      = free_hit ? free_onehot : '0;

`ifdef XDMA_ID_ALLOC_BYPASS_EN
  assign next_free = (~busy_q & ~accept_onehot & ValidMask) | free_clr;
`else
  assign next_free = ~busy_q & ~accept_onehot & ValidMask;
`endif

  find_first_one_idx #(.N(N)) u_ffo (
    .in_i    (next_free),
    .valid_o (ffo_valid),
    .idx_o   (ffo_idx)
  );

  always_comb begin
    state_d     = state_q;
    offer_idx_d = offer_idx_q;
    busy_d      = (busy_q | accept_onehot) & ~free_clr;
    count_d     = count_q + CntW'(accept) - CntW'(free_hit);
    err_d       = free_valid_i & ~free_hit;
    // Only a stalled offer holds; IDLE and accepted offers reload every cycle.
    if (!(state_q == OFFER && !alloc_ready_i)) begin
      state_d     = ffo_valid ? OFFER : IDLE;
      offer_idx_d = ffo_idx;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      offer_idx_q <= '0;
      busy_q      <= '0;
      count_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      offer_idx_q <= offer_idx_d;
      busy_q      <= busy_d;
      count_q     <= count_d;
      err_q       <= err_d;
    end
  end

endmodule
